gpio_port: RTL and testbench

GPIO_PORT -- requirements
Module: gpio_port

---
 rtl/gpio_pkg.sv | 26 ++
 rtl/gpio_port_if.sv | 11 +
 rtl/gpio_sync_edge.sv | 49 ++++
 rtl/gpio_port.sv | 103 ++++++++++
 tb/tb_gpio_port.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port: register map indices, window geometry
// and the post-reset edge suppression length.
package gpio_pkg;

  typedef enum logic [2:0] {
    REG_OUT  = 3'd0,
    REG_DIR  = 3'd1,
    REG_IN   = 3'd2,
    REG_EN   = 3'd3,
    REG_EDGE = 3'd4,
    REG_STAT = 3'd5,
    REG_SET  = 3'd6,
    REG_CLR  = 3'd7
  } reg_idx_e;

  localparam int unsigned WINDOW_BYTES    = 32;
  localparam int unsigned SUPPRESS_CYCLES = 2;

  // Expands byte-lane write enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    for (int unsigned n = 0; n < 4; n++) begin
      lane_mask[8*n +: 8] = {8{strb[n]}};
    end
  endfunction

endpackage

// File: rtl/gpio_port_if.sv
// Core-side register bus of the GPIO port.
interface gpio_port_if;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        rd_strobe;
  logic [3:0]  wr_strobe;
  logic [31:0] data_out;

  modport master (output addr, data_in, rd_strobe, wr_strobe, input data_out);
  modport slave  (input addr, data_in, rd_strobe, wr_strobe, output data_out);
endinterface

// File: rtl/gpio_sync_edge.sv
// Pad input synchronizer with polarity-qualified edge detection and a short
// post-reset blanking window.
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] edge_pol,
  output logic [WIDTH-1:0] pin_sync,
  output logic [WIDTH-1:0] edge_evt
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [1:0]       cnt;
  logic             suppress;

  assign suppress = (cnt != '0);

  // While blanked, prev tracks the value sync2 is about to take, so pins that
  // were already high when reset released compare equal once blanking ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      cnt   <= 2'(SUPPRESS_CYCLES);
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
      prev  <= suppress ? sync1 : sync2;
      if (suppress) cnt <= cnt - 2'd1;
    end
  end

  always_comb begin
    edge_evt = '0;
    if (!suppress) begin
      edge_evt = (sync2 & ~prev & edge_pol) | (~sync2 & prev & ~edge_pol);
    end
  end

  assign pin_sync = sync2;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: output/direction registers, synchronized inputs
// and sticky edge-status interrupt.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic             clk,
  input  logic             rst,
  gpio_port_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam int unsigned OFS_BITS = $clog2(WINDOW_BYTES);

  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] en_r;
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH-1:0] stat_r;
  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] stat_clr;
  logic [31:0]      wdata32;
  logic [31:0]      wmask32;
  logic [31:0]      rd_val;
  logic             sel;
  logic             wr_any;
  reg_idx_e         idx;
  logic             unused_bits;

  gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .pin_in   (gpio_in),
    .edge_pol (edge_r),
    .pin_sync (pin_sync),
    .edge_evt (edge_evt)
  );

  assign sel         = (bus.addr[31:OFS_BITS] == BASE_ADDR[31:OFS_BITS]);
  assign idx         = reg_idx_e'(bus.addr[4:2]);
  assign wmask32     = lane_mask(bus.wr_strobe);
  assign wdata32     = bus.data_in & wmask32;
  assign wmask       = wmask32[WIDTH-1:0];
  assign wbits       = wdata32[WIDTH-1:0];
  assign wr_any      = sel && (bus.wr_strobe != '0);
  assign stat_clr    = (wr_any && idx == REG_STAT) ? wbits : '0;
  assign unused_bits = ^{bus.addr[1:0], wdata32};

  always_comb begin
    rd_val = '0;
    if (sel) begin
      case (idx)
        REG_OUT:  rd_val[WIDTH-1:0] = out_r;
        REG_DIR:  rd_val[WIDTH-1:0] = dir_r;
        REG_IN:   rd_val[WIDTH-1:0] = pin_sync;
        REG_EN:   rd_val[WIDTH-1:0] = en_r;
        REG_EDGE: rd_val[WIDTH-1:0] = edge_r;
        REG_STAT: rd_val[WIDTH-1:0] = stat_r;
        default:  rd_val = '0;
      endcase
    end
  end

  // Read data comes from pre-edge register values, so a simultaneous write
  // is not visible until the following read.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r        <= '0;
      dir_r        <= '0;
      en_r         <= '0;
      edge_r       <= '0;
      stat_r       <= '0;
      bus.data_out <= '0;
    end else begin
      if (bus.rd_strobe) bus.data_out <= rd_val;
      stat_r <= (stat_r & ~stat_clr) | edge_evt;
      if (wr_any) begin
        case (idx)
          REG_OUT:  out_r  <= (out_r & ~wmask) | wbits;
          REG_DIR:  dir_r  <= (dir_r & ~wmask) | wbits;
          REG_EN:   en_r   <= (en_r & ~wmask) | wbits;
          REG_EDGE: edge_r <= (edge_r & ~wmask) | wbits;
          REG_SET:  out_r  <= out_r | wbits;
          REG_CLR:  out_r  <= out_r & ~wbits;
          default:  ;
        endcase
      end
    end
  end

  assign gpio_out = out_r;
  assign gpio_oe  = dir_r;
  assign irq      = |(stat_r & en_r);

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: register-map vector table plus edge/IRQ and
// reset sequences, and a narrow WIDTH=5 instance.
module tb_gpio_port;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_OUT  = BASE + 32'h00;
  localparam logic [31:0] A_DIR  = BASE + 32'h04;
  localparam logic [31:0] A_IN   = BASE + 32'h08;
  localparam logic [31:0] A_EN   = BASE + 32'h0C;
  localparam logic [31:0] A_EDGE = BASE + 32'h10;
  localparam logic [31:0] A_STAT = BASE + 32'h14;
  localparam logic [31:0] A_SET  = BASE + 32'h18;
  localparam logic [31:0] A_CLR  = BASE + 32'h1C;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_port_if bus ();
  gpio_port_if bus5 ();

  logic [7:0] gpio_in, gpio_out, gpio_oe;
  logic       irq;
  logic [4:0] gpio_in5, gpio_out5, gpio_oe5;
  logic       irq5;

  gpio_port #(.WIDTH(8), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  gpio_port #(.WIDTH(5), .BASE_ADDR(BASE)) u_dut5 (
    .clk(clk), .rst(rst), .bus(bus5),
    .gpio_in(gpio_in5), .gpio_out(gpio_out5), .gpio_oe(gpio_oe5), .irq(irq5)
  );

  typedef struct {
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_dout;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic rd, input logic [3:0] wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] dout,
                     input logic [7:0] o, input logic [7:0] oe);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d;
    v.exp_dout = dout; v.exp_out = o; v.exp_oe = oe;
    vecs.push_back(v);
  endtask

  task automatic bus_cycle(input logic rd, input logic [3:0] wr,
                           input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.data_in = d; bus.rd_strobe = rd; bus.wr_strobe = wr;
    @(posedge clk); #1;
    bus.rd_strobe = 1'b0; bus.wr_strobe = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_cycle(1'b0, s, a, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_cycle(1'b1, 4'b0000, a, 32'h0);
    d = bus.data_out;
  endtask

  task automatic bus5_cycle(input logic rd, input logic [3:0] wr,
                            input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus5.addr = a; bus5.data_in = d; bus5.rd_strobe = rd; bus5.wr_strobe = wr;
    @(posedge clk); #1;
    bus5.rd_strobe = 1'b0; bus5.wr_strobe = '0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    gpio_in = '0; gpio_in5 = '0;
    bus.addr = '0;  bus.data_in = '0;  bus.rd_strobe = 1'b0;  bus.wr_strobe = '0;
    bus5.addr = '0; bus5.data_in = '0; bus5.rd_strobe = 1'b0; bus5.wr_strobe = '0;

    // Register map: rd, wr, addr, wdata, expected data_out/gpio_out/gpio_oe
    add(0, 4'b0001, A_OUT,         32'h0000_00A5, 32'h00, 8'hA5, 8'h00);
    add(1, 4'b0000, A_OUT,         32'h0,         32'hA5, 8'hA5, 8'h00);
    add(0, 4'b0010, A_OUT,         32'h0000_5A00, 32'hA5, 8'hA5, 8'h00);
    add(0, 4'b0000, A_OUT,         32'hFFFF_FF3C, 32'hA5, 8'hA5, 8'h00);
    add(0, 4'b1111, BASE + 32'h05, 32'h0000_00FF, 32'hA5, 8'hA5, 8'hFF);
    add(1, 4'b0000, BASE + 32'h06, 32'h0,         32'hFF, 8'hA5, 8'hFF);
    add(0, 4'b0001, A_OUT,         32'h0000_00F0, 32'hFF, 8'hF0, 8'hFF);
    add(0, 4'b0001, A_SET,         32'h0000_000F, 32'hFF, 8'hFF, 8'hFF);
    add(0, 4'b0001, A_CLR,         32'h0000_0030, 32'hFF, 8'hCF, 8'hFF);
    add(1, 4'b0000, A_OUT,         32'h0,         32'hCF, 8'hCF, 8'hFF);
    add(1, 4'b0000, A_SET,         32'h0,         32'h00, 8'hCF, 8'hFF);
    add(1, 4'b0000, A_OUT,         32'h0,         32'hCF, 8'hCF, 8'hFF);
    add(1, 4'b0000, A_CLR,         32'h0,         32'h00, 8'hCF, 8'hFF);
    add(0, 4'b1111, BASE + 32'h20, 32'h0,         32'h00, 8'hCF, 8'hFF);
    add(1, 4'b0000, A_OUT,         32'h0,         32'hCF, 8'hCF, 8'hFF);
    add(1, 4'b0000, 32'h2000_0000, 32'h0,         32'h00, 8'hCF, 8'hFF);
    add(1, 4'b0000, A_DIR,         32'h0,         32'hFF, 8'hCF, 8'hFF);
    add(0, 4'b1111, A_IN,          32'hFFFF_FFFF, 32'hFF, 8'hCF, 8'hFF);
    add(1, 4'b0000, A_IN,          32'h0,         32'h00, 8'hCF, 8'hFF);
    add(1, 4'b0001, A_OUT,         32'h0000_0011, 32'hCF, 8'h11, 8'hFF);
    add(1, 4'b0000, A_OUT,         32'h0,         32'h11, 8'h11, 8'hFF);
    add(0, 4'b1111, A_DIR,         32'h0,         32'h11, 8'h11, 8'h00);
    add(0, 4'b0001, A_OUT,         32'h0,         32'h11, 8'h00, 8'h00);
    add(0, 4'b0010, A_SET,         32'h0000_FF00, 32'h11, 8'h00, 8'h00);
    add(0, 4'b0000, A_SET,         32'h0000_00FF, 32'h11, 8'h00, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    check("reset gpio_out", 32'(gpio_out), 32'h0);
    check("reset gpio_oe", 32'(gpio_oe), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset data_out", bus.data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    for (int i = 0; i < vecs.size(); i++) begin
      bus_cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d data_out", i), bus.data_out, vecs[i].exp_dout);
      check($sformatf("v%0d gpio_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
      check($sformatf("v%0d gpio_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
    end

    // Rising edge on pin 0 with interrupt enabled: irq after edge k+2
    bus_write(A_EN, 32'h01, 4'b0001);
    bus_write(A_EDGE, 32'h01, 4'b0001);
    @(negedge clk); gpio_in[0] = 1'b1;
    @(posedge clk); #1; check("rise0 irq k", 32'(irq), 32'h0);
    @(posedge clk); #1; check("rise0 irq k+1", 32'(irq), 32'h0);
    @(posedge clk); #1; check("rise0 irq k+2", 32'(irq), 32'h1);
    bus_read(A_STAT, rdata); check("rise0 stat", rdata, 32'h01);
    bus_write(A_STAT, 32'h01, 4'b0001);
    check("w1c0 irq", 32'(irq), 32'h0);
    bus_read(A_STAT, rdata); check("w1c0 stat", rdata, 32'h00);
    @(negedge clk); gpio_in[0] = 1'b0;
    idle(4);
    bus_read(A_STAT, rdata); check("fall0 ignored", rdata, 32'h00);

    // Falling polarity on pin 1, not enabled for irq
    bus_write(A_EDGE, 32'h00, 4'b0001);
    @(negedge clk); gpio_in[1] = 1'b1;
    idle(4);
    bus_read(A_STAT, rdata); check("rise1 ignored", rdata, 32'h00);
    @(negedge clk); gpio_in[1] = 1'b0;
    idle(4);
    bus_read(A_STAT, rdata); check("fall1 stat", rdata, 32'h02);
    check("fall1 irq masked", 32'(irq), 32'h0);
    bus_write(A_STAT, 32'h02, 4'b0001);

    // New edge on pin 2 lands in the same cycle as a W1C of that bit
    bus_write(A_EDGE, 32'h04, 4'b0001);
    @(negedge clk); gpio_in[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    bus_write(A_STAT, 32'h04, 4'b0001);
    bus_read(A_STAT, rdata); check("edge beats w1c", rdata, 32'h04);
    bus_write(A_STAT, 32'h04, 4'b0001);
    bus_read(A_STAT, rdata); check("w1c2 stat", rdata, 32'h00);

    // Reset aborts an access; pins high through reset release raise nothing
    bus_write(A_OUT, 32'h3C, 4'b0001);
    check("pre-rst gpio_out", 32'(gpio_out), 32'h3C);
    @(negedge clk); gpio_in = 8'hFF;
    idle(4);
    @(negedge clk);
    rst = 1'b1;
    bus.addr = A_OUT; bus.data_in = 32'hFF; bus.wr_strobe = 4'b0001; bus.rd_strobe = 1'b1;
    @(posedge clk); #1;
    bus.wr_strobe = '0; bus.rd_strobe = 1'b0;
    check("rst abort gpio_out", 32'(gpio_out), 32'h0);
    check("rst abort data_out", bus.data_out, 32'h0);
    check("rst irq", 32'(irq), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    bus_write(A_EDGE, 32'hFF, 4'b0001);
    bus_write(A_EN, 32'hFF, 4'b0001);
    idle(4);
    bus_read(A_STAT, rdata); check("rst release stat", rdata, 32'h00);
    check("rst release irq", 32'(irq), 32'h0);
    bus_read(A_IN, rdata); check("in sync", rdata, 32'hFF);
    @(negedge clk); gpio_in[3] = 1'b0;
    idle(4);
    @(negedge clk); gpio_in[3] = 1'b1;
    idle(4);
    bus_read(A_STAT, rdata); check("post-blank edge stat", rdata, 32'h08);
    check("post-blank irq", 32'(irq), 32'h1);

    // Narrow instance: upper bits discarded, out-of-window reads are zero
    bus5_cycle(1'b0, 4'b1111, A_DIR, 32'hFFFF_FFFF);
    check("w5 gpio_oe", 32'(gpio_oe5), 32'h1F);
    bus5_cycle(1'b1, 4'b0000, A_DIR, 32'h0);
    check("w5 dir read", bus5.data_out, 32'h1F);
    bus5_cycle(1'b1, 4'b0000, BASE + 32'h20, 32'h0);
    check("w5 window+0x20", bus5.data_out, 32'h0);
    bus5_cycle(1'b0, 4'b1111, A_SET, 32'hFFFF_FFFF);
    bus5_cycle(1'b1, 4'b0000, A_OUT, 32'h0);
    check("w5 out read", bus5.data_out, 32'h1F);
    check("w5 gpio_out", 32'(gpio_out5), 32'h1F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
